// File: rtl/bambu_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bambu_uart_pkg                                                     |
// | Shared UART constants: one-hot FSM encoding and parity modes.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package bambu_uart_pkg;

    localparam int c_state_w = 5;

    localparam logic [c_state_w-1:0] c_st_idle   = 5'b00001;
    localparam logic [c_state_w-1:0] c_st_start  = 5'b00010;
    localparam logic [c_state_w-1:0] c_st_data   = 5'b00100;
    localparam logic [c_state_w-1:0] c_st_parity = 5'b01000;
    localparam logic [c_state_w-1:0] c_st_stop   = 5'b10000;

    localparam int c_parity_none = 0;
    localparam int c_parity_odd  = 1;
    localparam int c_parity_even = 2;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == c_parity_odd) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bambu_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bambu_baud_tick                                                    |
// | Free-running 0..CLKS_PER_BIT-1 counter with sync clear; bit_tick   |
// | marks the last cycle of each bit period.                           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module bambu_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign o_bit_tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/bambu_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bambu_uart_tx                                                      |
// | UART transmitter with one-byte holding register; frames chain with |
// | no idle gap while the holding register is refilled in time.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module bambu_uart_tx
    import bambu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_ENABLE,
    output logic       TX_READY,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam logic [2:0] c_stop_last = 3'(STOP_BITS - 1);
    localparam logic [2:0] c_bit_last  = 3'd7;

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic [7:0]           r_hold;
    logic                 r_hold_valid;
    logic                 r_ready;
    logic                 r_overrun;
    logic                 w_load;
    logic                 w_bit_tick;
    logic                 w_baud_clear;

    // Counter sits at zero while idle so a fresh start bit gets a full period.
    assign w_baud_clear = (r_state == c_st_idle);

    bambu_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_baud_clear),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_tx         <= 1'b1;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_par        <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_overrun    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_par     <= w_par_nxt;
            if (w_load) begin
                r_hold_valid <= 1'b0;
                r_ready      <= 1'b1;
            end
            // A drain implies ready is low, so accept and drain never collide.
            if (TX_ENABLE) begin
                if (r_ready) begin
                    r_hold       <= TX_DATA;
                    r_hold_valid <= 1'b1;
                    r_ready      <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (w_bit_tick) w_state_nxt = c_st_data;
            end
            c_st_data: begin
                if (w_bit_tick && (r_bit_idx == c_bit_last)) begin
                    w_state_nxt = (PARITY != c_parity_none) ? c_st_parity : c_st_stop;
                end
            end
            c_st_parity: begin
                if (w_bit_tick) w_state_nxt = c_st_stop;
            end
            c_st_stop: begin
                if (w_bit_tick && (r_bit_idx == c_stop_last)) begin
                    if (r_hold_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_st_start;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_tx_nxt      = r_tx;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_par_nxt     = r_par;
        if (w_load) begin
            w_shift_nxt   = r_hold;
            w_par_nxt     = parity_bit(r_hold, PARITY);
            w_bit_idx_nxt = '0;
            w_tx_nxt      = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: w_tx_nxt = 1'b1;
                c_st_start: begin
                    if (w_bit_tick) begin
                        w_tx_nxt      = r_shift[0];
                        w_bit_idx_nxt = '0;
                    end
                end
                c_st_data: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == c_bit_last) begin
                            w_tx_nxt      = (PARITY != c_parity_none) ? r_par : 1'b1;
                            w_bit_idx_nxt = '0;
                        end else begin
                            w_tx_nxt      = r_shift[1];
                            w_shift_nxt   = {1'b0, r_shift[7:1]};
                            w_bit_idx_nxt = r_bit_idx + 3'd1;
                        end
                    end
                end
                c_st_parity: begin
                    if (w_bit_tick) begin
                        w_tx_nxt      = 1'b1;
                        w_bit_idx_nxt = '0;
                    end
                end
                c_st_stop: begin
                    w_tx_nxt = 1'b1;
                    if (w_bit_tick) begin
                        w_bit_idx_nxt = (r_bit_idx == c_stop_last) ? 3'd0 : r_bit_idx + 3'd1;
                    end
                end
                default: w_tx_nxt = 1'b1;
            endcase
        end
    end

    // Ready drops during a strobe so upstream never sees a stale 1 the cycle after.
    assign TX_READY = r_ready & ~TX_ENABLE;
    assign tx       = r_tx;
    assign busy     = (r_state != c_st_idle) | r_hold_valid;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire
